alarm_controller: RTL and testbench



---
 rtl/alarm_clock_pkg.sv | 49 ++++
 rtl/bcd_time_counter.sv | 54 +++++
 rtl/alarm_controller.sv | 103 ++++++++++
 tb/tb_alarm_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared key codes, FSM state, BCD time type and time helpers for the alarm clock.
// Times are packed as {H1,H0,M1,M0}, one BCD digit per nibble.
package alarm_clock_pkg;

  localparam logic [3:0] KEY_LOAD_TIME  = 4'd10;
  localparam logic [3:0] KEY_LOAD_ALARM = 4'd11;
  localparam logic [3:0] KEY_CLEAR      = 4'd12;

  typedef enum logic {IDLE, ENTRY} state_t;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  function automatic logic time_is_valid(input bcd_time_t t);
    return (t.h1 <= 4'd2) && (t.h0 <= 4'd9) && (t.m1 <= 4'd5) && (t.m0 <= 4'd9) &&
           !((t.h1 == 4'd2) && (t.h0 > 4'd3));
  endfunction

  // Advance a valid HH:MM by one minute, wrapping 23:59 to 00:00.
  function automatic bcd_time_t next_minute(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.m0 != 4'd9) begin
      n.m0 = t.m0 + 4'd1;
    end else begin
      n.m0 = 4'd0;
      if (t.m1 != 4'd5) begin
        n.m1 = t.m1 + 4'd1;
      end else begin
        n.m1 = 4'd0;
        if ((t.h1 == 4'd2) && (t.h0 == 4'd3)) begin
          n.h1 = 4'd0;
          n.h0 = 4'd0;
        end else if (t.h0 == 4'd9) begin
          n.h1 = t.h1 + 4'd1;
          n.h0 = 4'd0;
        end else begin
          n.h0 = t.h0 + 4'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Prescaler, seconds counter and BCD HH:MM clock with a synchronous load.
// A load clears the sub-minute state and overrides any tick in the same cycle.
module bcd_time_counter
  import alarm_clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] current_time,
  output logic        one_second
);

  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0] PRESCALE_PRE = PW'(CLK_PER_SEC - 2);

  logic [PW-1:0] prescale;
  logic [5:0]    seconds;
  bcd_time_t     time_q;

  // one_second is registered one count early so it is high exactly while prescale is at its maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale   <= '0;
      seconds    <= '0;
      time_q     <= '0;
      one_second <= 1'b0;
    end else if (load) begin
      prescale   <= '0;
      seconds    <= '0;
      time_q     <= bcd_time_t'(load_value);
      one_second <= 1'b0;
    end else begin
      one_second <= (prescale == PRESCALE_PRE);
      if (prescale == PRESCALE_MAX) begin
        prescale <= '0;
        if (seconds == 6'd59) begin
          seconds <= '0;
          time_q  <= next_minute(time_q);
        end else begin
          seconds <= seconds + 6'd1;
        end
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

  assign current_time = time_q;

endmodule

// File: rtl/alarm_controller.sv
// Keypad entry FSM, alarm register and display selects around the running BCD clock.
// Feeds show_alarm / show_new_time to lcd_driver; entry display has priority over alarm display.
module alarm_controller
  import alarm_clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 256,
  parameter int TIMEOUT_SEC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key,
  input  logic        key_valid,
  input  logic        alarm_button,
  output logic [15:0] key_buffer,
  output logic [15:0] current_time,
  output logic [15:0] alarm_time,
  output logic        show_alarm,
  output logic        show_new_time,
  output logic        one_second
);

  localparam int TW = $clog2(TIMEOUT_SEC + 1) < 1 ? 1 : $clog2(TIMEOUT_SEC + 1);

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timeout_cnt;
  logic          button_q;
  logic          key_is_digit;
  logic          key_accepted;
  logic          buffer_valid;
  logic          timeout_hit;
  logic          load_time;
  logic          load_alarm;

  assign key_is_digit = key_valid && (key <= 4'd9);
  assign key_accepted = key_valid && (key <= KEY_CLEAR);
  assign buffer_valid = time_is_valid(bcd_time_t'(key_buffer));
  assign timeout_hit  = (state == ENTRY) && one_second && (timeout_cnt == TW'(TIMEOUT_SEC - 1));
  assign load_time    = (state == ENTRY) && key_valid && (key == KEY_LOAD_TIME) && buffer_valid;
  assign load_alarm   = (state == ENTRY) && key_valid && (key == KEY_LOAD_ALARM) && buffer_valid;

  bcd_time_counter #(
    .CLK_PER_SEC (CLK_PER_SEC)
  ) u_time (
    .clk          (clk),
    .reset        (reset),
    .load         (load_time),
    .load_value   (key_buffer),
    .current_time (current_time),
    .one_second   (one_second)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A real key press in ENTRY always beats the timeout, since it also restarts the idle count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (key_is_digit) state_next = ENTRY;
      end
      ENTRY: begin
        if (key_accepted) begin
          if (!key_is_digit) state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    show_new_time = (state == ENTRY);
    show_alarm    = button_q && (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_buffer  <= '0;
      alarm_time  <= '0;
      timeout_cnt <= '0;
      button_q    <= 1'b0;
    end else begin
      button_q <= alarm_button;
      if (key_is_digit) begin
        key_buffer <= (state == IDLE) ? {12'h000, key} : {key_buffer[11:0], key};
      end else if ((state == ENTRY) && key_valid && (key == KEY_CLEAR)) begin
        key_buffer <= '0;
      end
      if (load_alarm) alarm_time <= key_buffer;
      if ((state != ENTRY) || key_accepted) begin
        timeout_cnt <= '0;
      end else if (one_second) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: expectations are queued as stimulus is applied
// and popped against the DUT outputs once the response is due.
module tb_alarm_controller;
  import alarm_clock_pkg::*;

  localparam int CPS = 4;
  localparam int TOS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key;
  logic        key_valid;
  logic        alarm_button;
  logic [15:0] key_buffer;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        show_alarm;
  logic        show_new_time;
  logic        one_second;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef enum int {SEL_TIME, SEL_ALARM, SEL_BUFFER, SEL_SHOW_ALARM, SEL_SHOW_NEW, SEL_PULSE} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [15:0] value;
  } expect_t;

  expect_t sb[$];

  always #5 clk = ~clk;

  alarm_controller #(
    .CLK_PER_SEC (CPS),
    .TIMEOUT_SEC (TOS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key           (key),
    .key_valid     (key_valid),
    .alarm_button  (alarm_button),
    .key_buffer    (key_buffer),
    .current_time  (current_time),
    .alarm_time    (alarm_time),
    .show_alarm    (show_alarm),
    .show_new_time (show_new_time),
    .one_second    (one_second)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] observe(input sel_t sel);
    case (sel)
      SEL_TIME:       return current_time;
      SEL_ALARM:      return alarm_time;
      SEL_BUFFER:     return key_buffer;
      SEL_SHOW_ALARM: return {15'h0, show_alarm};
      SEL_SHOW_NEW:   return {15'h0, show_new_time};
      SEL_PULSE:      return {15'h0, one_second};
      default:        return 16'hxxxx;
    endcase
  endfunction

  task automatic expectOut(input sel_t sel, input string tag, input logic [15:0] value);
    expect_t e;
    e.tag   = tag;
    e.sel   = sel;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic drainScoreboard();
    expect_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, observe(e.sel), e.value);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    @(negedge clk);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enterDigits(input logic [15:0] digits);
    logic [15:0] d;
    d = digits;
    applyStimulus(d[15:12]);
    applyStimulus(d[11:8]);
    applyStimulus(d[7:4]);
    applyStimulus(d[3:0]);
  endtask

  // Returns one negedge after the n-th pulse, so that pulse's effect is visible.
  task automatic waitSeconds(input int n, input string tag);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while ((seen < n) && (cyc < n * CPS * 2 + 8)) begin
      @(negedge clk);
      cyc++;
      if (one_second) seen++;
    end
    @(negedge clk);
    checkOutput(tag, 16'(seen), 16'(n));
  endtask

  task automatic loadAndRoll(input logic [15:0] start, input logic [15:0] rolled, input string tag);
    enterDigits(start);
    expectOut(SEL_BUFFER, {tag, "_buf"}, start);
    expectOut(SEL_SHOW_NEW, {tag, "_entry"}, 16'h1);
    drainScoreboard();
    applyStimulus(KEY_LOAD_TIME);
    expectOut(SEL_TIME, {tag, "_load"}, start);
    expectOut(SEL_SHOW_NEW, {tag, "_idle"}, 16'h0);
    drainScoreboard();
    waitSeconds(60, {tag, "_secs"});
    expectOut(SEL_TIME, {tag, "_roll"}, rolled);
    drainScoreboard();
  endtask

  initial begin
    int cyc;
    int seen;
    int first_pulse;
    int last_pulse;
    int guard;

    reset        = 1'b1;
    key          = 4'd0;
    key_valid    = 1'b0;
    alarm_button = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expectOut(SEL_TIME, "rst_time", 16'h0000);
    expectOut(SEL_ALARM, "rst_alarm", 16'h0000);
    expectOut(SEL_BUFFER, "rst_buf", 16'h0000);
    expectOut(SEL_SHOW_ALARM, "rst_show_alarm", 16'h0);
    expectOut(SEL_SHOW_NEW, "rst_show_new", 16'h0);
    expectOut(SEL_PULSE, "rst_pulse", 16'h0);
    drainScoreboard();
    reset = 1'b0;

    cyc         = 0;
    seen        = 0;
    first_pulse = -1;
    last_pulse  = -1;
    while ((seen < 60) && (cyc < 400)) begin
      @(negedge clk);
      cyc++;
      if (one_second) begin
        seen++;
        if (first_pulse < 0) first_pulse = cyc;
        last_pulse = cyc;
      end
    end
    @(negedge clk);
    checkOutput("first_pulse_cycle", 16'(first_pulse), 16'(CPS - 1));
    checkOutput("pulse_span", 16'(last_pulse - first_pulse), 16'(59 * CPS));
    checkOutput("pulse_count", 16'(seen), 16'd60);
    expectOut(SEL_TIME, "one_minute", 16'h0001);
    drainScoreboard();

    loadAndRoll(16'h2359, 16'h0000, "day_wrap");
    loadAndRoll(16'h0959, 16'h1000, "h0_carry");
    loadAndRoll(16'h1959, 16'h2000, "h1_carry");

    enterDigits(16'h1234);
    guard = 0;
    while (!one_second && (guard < 20)) begin
      @(negedge clk);
      guard++;
    end
    expectOut(SEL_PULSE, "tick_align", 16'h1);
    drainScoreboard();
    key       = KEY_LOAD_TIME;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    expectOut(SEL_TIME, "tick_load", 16'h1234);
    drainScoreboard();
    waitSeconds(59, "tick_secs59");
    expectOut(SEL_TIME, "tick_59s", 16'h1234);
    drainScoreboard();
    waitSeconds(1, "tick_secs1");
    expectOut(SEL_TIME, "tick_60s", 16'h1235);
    drainScoreboard();

    enterDigits(16'h2400);
    applyStimulus(KEY_LOAD_TIME);
    expectOut(SEL_TIME, "bad_hour", 16'h1235);
    expectOut(SEL_SHOW_NEW, "bad_hour_idle", 16'h0);
    drainScoreboard();
    enterDigits(16'h1260);
    applyStimulus(KEY_LOAD_TIME);
    expectOut(SEL_TIME, "bad_min", 16'h1235);
    expectOut(SEL_SHOW_NEW, "bad_min_idle", 16'h0);
    drainScoreboard();
    enterDigits(16'h1260);
    applyStimulus(KEY_LOAD_ALARM);
    expectOut(SEL_ALARM, "bad_alarm", 16'h0000);
    expectOut(SEL_SHOW_NEW, "bad_alarm_idle", 16'h0);
    drainScoreboard();

    enterDigits(16'h0730);
    expectOut(SEL_SHOW_NEW, "alarm_entry", 16'h1);
    drainScoreboard();
    applyStimulus(KEY_LOAD_ALARM);
    expectOut(SEL_ALARM, "alarm_load", 16'h0730);
    expectOut(SEL_SHOW_NEW, "alarm_idle", 16'h0);
    drainScoreboard();
    applyStimulus(KEY_LOAD_ALARM);
    expectOut(SEL_ALARM, "idle_cmd_ignored", 16'h0730);
    expectOut(SEL_SHOW_NEW, "idle_cmd_state", 16'h0);
    drainScoreboard();

    @(negedge clk);
    alarm_button = 1'b1;
    expectOut(SEL_SHOW_ALARM, "show_alarm_lag", 16'h0);
    drainScoreboard();
    @(negedge clk);
    expectOut(SEL_SHOW_ALARM, "show_alarm_on", 16'h1);
    drainScoreboard();
    applyStimulus(4'd1);
    expectOut(SEL_SHOW_ALARM, "entry_priority", 16'h0);
    expectOut(SEL_SHOW_NEW, "entry_show", 16'h1);
    expectOut(SEL_BUFFER, "entry_first", 16'h0001);
    drainScoreboard();
    applyStimulus(4'd13);
    expectOut(SEL_BUFFER, "key13_ignored", 16'h0001);
    expectOut(SEL_SHOW_NEW, "key13_state", 16'h1);
    drainScoreboard();
    applyStimulus(KEY_CLEAR);
    expectOut(SEL_BUFFER, "clear_buf", 16'h0000);
    expectOut(SEL_SHOW_NEW, "clear_idle", 16'h0);
    expectOut(SEL_SHOW_ALARM, "clear_show_alarm", 16'h1);
    drainScoreboard();
    alarm_button = 1'b0;
    @(negedge clk);
    expectOut(SEL_SHOW_ALARM, "show_alarm_off", 16'h0);
    drainScoreboard();

    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    applyStimulus(4'd5);
    expectOut(SEL_BUFFER, "shift_buf", 16'h2345);
    drainScoreboard();
    waitSeconds(TOS - 1, "timeout_secs_a");
    expectOut(SEL_SHOW_NEW, "timeout_not_yet", 16'h1);
    drainScoreboard();
    waitSeconds(1, "timeout_secs_b");
    expectOut(SEL_SHOW_NEW, "timeout_idle", 16'h0);
    expectOut(SEL_BUFFER, "timeout_buf_kept", 16'h2345);
    drainScoreboard();

    applyStimulus(4'd1);
    applyStimulus(4'd2);
    expectOut(SEL_BUFFER, "pre_reset_buf", 16'h0012);
    drainScoreboard();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expectOut(SEL_BUFFER, "mid_reset_buf", 16'h0000);
    expectOut(SEL_SHOW_NEW, "mid_reset_show", 16'h0);
    expectOut(SEL_TIME, "mid_reset_time", 16'h0000);
    expectOut(SEL_ALARM, "mid_reset_alarm", 16'h0000);
    drainScoreboard();
    applyStimulus(KEY_LOAD_TIME);
    expectOut(SEL_TIME, "post_reset_load", 16'h0000);
    expectOut(SEL_SHOW_NEW, "post_reset_state", 16'h0);
    drainScoreboard();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
